// File: rtl/polar_pkg.sv
// Shared types, constants and helpers for the streaming polar encoder.
package polar_pkg;

    // Polar kernel F = [[1,0],[1,1]] packed row-major as {F00, F01, F10, F11}
    localparam logic [3:0] F_KERNEL = 4'b1011;

    localparam int         DEFAULT_N           = 8;
    localparam int         DEFAULT_K           = 4;
    localparam logic [7:0] DEFAULT_FROZEN_MASK = 8'b0001_0111;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ENCODE  = 2'd1,
        EMIT    = 2'd2
    } enc_state_t;

    function automatic int clog2_pow2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((1 << clog2_pow2(n)) == n);
    endfunction

    function automatic int bitrev(input int idx, input int width);
        int r;
        r = 0;
        for (int b = 0; b < width; b++) r = (r << 1) | ((idx >> b) & 1);
        return r;
    endfunction

endpackage

// File: rtl/polar_encoder_stream_if.sv
// Handshake bundle of the polar encoder: info-bit input stream, code-bit output stream, busy.
interface polar_encoder_stream_if;
    logic in_valid;
    logic in_bit;
    logic in_ready;
    logic out_valid;
    logic out_bit;
    logic out_last;
    logic out_ready;
    logic busy;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_bit, out_last, busy
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_bit, out_last, busy
    );
endinterface

// File: rtl/polar_butterfly_stage.sv
// One combinational butterfly stage of x = u*F^{(x)n}: pairs (i, i+2^s) with bit s of i clear.
module polar_butterfly_stage
    import polar_pkg::*;
#(
    parameter int N     = 8,
    parameter int LOG2N = 3,
    parameter int SW    = 2
) (
    input  logic [N-1:0]  v_in,
    input  logic [SW-1:0] s,
    output logic [N-1:0]  v_out
);

    logic [LOG2N-1:0][N-1:0] stg;

    for (genvar t = 0; t < LOG2N; t++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_pair
            if (((i >> t) & 1) == 0) begin : g_top
                assign stg[t][i]          = (v_in[i] & F_KERNEL[3]) ^ (v_in[i + (1 << t)] & F_KERNEL[1]);
                assign stg[t][i + (1 << t)] = (v_in[i] & F_KERNEL[2]) ^ (v_in[i + (1 << t)] & F_KERNEL[0]);
            end
        end
    end

    always_comb begin
        v_out = v_in;
        for (int t = 0; t < LOG2N; t++) begin
            if (s == SW'(t)) v_out = stg[t];
        end
    end

endmodule

// File: rtl/polar_encoder_stream.sv
// Streaming non-systematic polar encoder: collect K info bits, LOG2N butterfly cycles, emit N code bits.
// Define POLAR_ENC_BIT_REVERSE_EN to emit the codeword in bit-reversed index order.
module polar_encoder_stream
    import polar_pkg::*;
#(
    parameter int             N           = DEFAULT_N,
    parameter int             K           = DEFAULT_K,
    parameter logic [N-1:0]   FROZEN_MASK = DEFAULT_FROZEN_MASK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    polar_encoder_stream_if.slave bus
);

    localparam int LOG2N = $clog2(N);
    localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int CW    = $clog2(K + 1);

    if (!is_pow2(N)) begin : g_bad_n
        $error("polar_encoder_stream: N must be a power of two >= 2");
    end
    if ($countones(FROZEN_MASK) != N - K) begin : g_bad_mask
        $error("polar_encoder_stream: popcount(FROZEN_MASK) must equal N-K");
    end

    enc_state_t       state, state_next;
    logic [N-1:0]     v, v_next, v_stage;
    logic [CW-1:0]    cnt, cnt_next;
    logic [SW-1:0]    stage, stage_next;
    logic [LOG2N-1:0] idx, idx_next, emit_pos;
    logic             in_ready_c, out_valid_c, out_bit_c, out_last_c, busy_c;

    // Map the j-th info bit onto the j-th non-frozen u position.
    function automatic logic [LOG2N-1:0] info_index(input logic [CW-1:0] j);
        logic [LOG2N-1:0] pos;
        int               seen;
        pos  = '0;
        seen = 0;
        for (int i = 0; i < N; i++) begin
            if (!FROZEN_MASK[i]) begin
                if (seen == int'(j)) pos = LOG2N'(i);
                seen++;
            end
        end
        return pos;
    endfunction

    polar_butterfly_stage #(.N(N), .LOG2N(LOG2N), .SW(SW)) u_stage (
        .v_in  (v),
        .s     (stage),
        .v_out (v_stage)
    );

`ifdef POLAR_ENC_BIT_REVERSE_EN
    assign emit_pos = LOG2N'(bitrev(int'(idx), LOG2N));
`else
    assign emit_pos = idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            v     <= '0;
            cnt   <= '0;
            stage <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            v     <= v_next;
            cnt   <= cnt_next;
            stage <= stage_next;
            idx   <= idx_next;
        end
    end

    // The u/v register is reused in place: filled in COLLECT, transformed in ENCODE, read out in EMIT.
    always_comb begin
        state_next  = state;
        v_next      = v;
        cnt_next    = cnt;
        stage_next  = stage;
        idx_next    = idx;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_bit_c   = 1'b0;
        out_last_c  = 1'b0;
        busy_c      = (state != COLLECT) || (cnt != '0);

        case (state)
            COLLECT: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    v_next[info_index(cnt)] = bus.in_bit;
                    if (cnt == CW'(K - 1)) begin
                        cnt_next   = '0;
                        stage_next = '0;
                        state_next = ENCODE;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            ENCODE: begin
                v_next = v_stage;
                if (stage == SW'(LOG2N - 1)) begin
                    stage_next = '0;
                    idx_next   = '0;
                    state_next = EMIT;
                end else begin
                    stage_next = stage + SW'(1);
                end
            end
            EMIT: begin
                out_valid_c = 1'b1;
                out_bit_c   = v[emit_pos];
                out_last_c  = (idx == LOG2N'(N - 1));
                if (bus.out_ready) begin
                    if (out_last_c) begin
                        idx_next   = '0;
                        v_next     = '0;
                        state_next = COLLECT;
                    end else begin
                        idx_next = idx + LOG2N'(1);
                    end
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_bit   = out_bit_c;
    assign bus.out_last  = out_last_c;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_polar_encoder_stream.sv
// Directed bench for polar_encoder_stream (N=8, K=4, mask 0x17); expected codewords are hand-derived.
module tb_polar_encoder_stream;

    logic clk;
    logic rst_n;
    int   cycle;
    int   check_count;
    int   error_count;
    int   last_accept;
    int   last_xfer;
    int   saved_xfer;

    polar_encoder_stream_if bus ();

    polar_encoder_stream #(
        .N           (8),
        .K           (4),
        .FROZEN_MASK (8'b0001_0111)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input int got, input int exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Feeds nbits info bits (bit 0 first); hold_valid keeps in_valid high for a following frame.
    task automatic applyStimulus(input logic [3:0] bits, input int nbits, input logic hold_valid);
        int guard;
        for (int j = 0; j < nbits; j++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = bits[j];
            guard = 0;
            while (!bus.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.in_ready) begin
                checkOutput("accept timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            last_accept = cycle;
            @(posedge clk);
            @(negedge clk);
        end
        if (!hold_valid) bus.in_valid = 1'b0;
    endtask

    // x_nat bit i holds x[i]; pattern gives out_ready per EMIT cycle (bit 0 first, repeating).
    task automatic collectOutput(input string tag, input logic [7:0] x_nat, input logic [3:0] pattern);
        int         got, k, guard;
        logic       held_bit, held_last, stalled;
        logic [2:0] g, pos;
        got = 0; k = 0; guard = 0; stalled = 1'b0;
        held_bit = 1'b0; held_last = 1'b0;
        bus.out_ready = 1'b0;
        while (!bus.out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.out_valid) begin
            checkOutput({tag, " out_valid timeout"}, 0, 1);
            return;
        end
        checkOutput({tag, " latency"}, cycle - last_accept, 4);
        guard = 0;
        while (got < 8 && guard < 200) begin
            if (bus.out_valid) begin
                checkOutput({tag, " in_ready low"}, bus.in_ready, 0);
                if (stalled) begin
                    checkOutput({tag, " stall bit"}, bus.out_bit, held_bit);
                    checkOutput({tag, " stall last"}, bus.out_last, held_last);
                end
                if (pattern[k % 4]) begin
                    g = 3'(got);
`ifdef POLAR_ENC_BIT_REVERSE_EN
                    pos = {g[0], g[1], g[2]};
`else
                    pos = g;
`endif
                    checkOutput($sformatf("%s x%0d", tag, got), bus.out_bit, x_nat[pos]);
                    checkOutput($sformatf("%s last%0d", tag, got), bus.out_last, (got == 7) ? 1 : 0);
                    if (got == 7) last_xfer = cycle;
                    got++;
                    stalled = 1'b0;
                    bus.out_ready = 1'b1;
                end else begin
                    held_bit  = bus.out_bit;
                    held_last = bus.out_last;
                    stalled   = 1'b1;
                    bus.out_ready = 1'b0;
                end
                k++;
            end else begin
                checkOutput({tag, " out_valid held"}, bus.out_valid, 1);
                bus.out_ready = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.out_ready = 1'b0;
        if (got < 8) checkOutput({tag, " transfer timeout"}, got, 8);
        checkOutput({tag, " out_valid after"}, bus.out_valid, 0);
        checkOutput({tag, " in_ready after"}, bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cycle = 0; check_count = 0; error_count = 0;
        last_accept = 0; last_xfer = 0; saved_xfer = 0;
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", bus.in_ready, 1);
        checkOutput("reset out_valid", bus.out_valid, 0);
        checkOutput("reset out_bit", bus.out_bit, 0);
        checkOutput("reset out_last", bus.out_last, 0);
        checkOutput("reset busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Info 1,1,1,1 -> u=[0,0,0,1,0,1,1,1] -> x=0,1,1,0,1,0,0,1
        applyStimulus(4'b1111, 4, 1'b0);
        checkOutput("encode busy", bus.busy, 1);
        collectOutput("all-ones", 8'b1001_0110, 4'b1111);

        // Only u7 -> all ones; only u3 -> 1,1,1,1,0,0,0,0
        applyStimulus(4'b1000, 4, 1'b0);
        collectOutput("u7", 8'b1111_1111, 4'b1111);
        applyStimulus(4'b0001, 4, 1'b0);
        collectOutput("u3", 8'b0000_1111, 4'b1111);

        // Only u5 -> 1,1,0,0,1,1,0,0 with backpressure 1,0,0,1
        applyStimulus(4'b0010, 4, 1'b0);
        collectOutput("u5 stall", 8'b0011_0011, 4'b1001);

        // Only u6 -> 1,0,1,0,1,0,1,0 with alternating backpressure
        applyStimulus(4'b0100, 4, 1'b0);
        collectOutput("u6 stall", 8'b0101_0101, 4'b0101);

        // Back-to-back frames with in_valid held high
        fork
            begin
                applyStimulus(4'b1111, 4, 1'b1);
                applyStimulus(4'b0001, 4, 1'b0);
            end
            begin
                collectOutput("b2b f1", 8'b1001_0110, 4'b1111);
                saved_xfer = last_xfer;
                collectOutput("b2b f2", 8'b0000_1111, 4'b1111);
            end
        join
        // applyStimulus leaves last_accept at the 4th accept of frame 2; first accept is 3 cycles earlier
        checkOutput("b2b restart", last_accept - 3, saved_xfer + 1);

        // Reset mid-frame after two info bits
        applyStimulus(4'b0011, 2, 1'b0);
        checkOutput("partial busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset in_ready", bus.in_ready, 1);
        checkOutput("midreset out_valid", bus.out_valid, 0);
        checkOutput("midreset busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'b1111, 4, 1'b0);
        collectOutput("after reset", 8'b1001_0110, 4'b1111);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/polar_encoder_stream.md
Name: polar_encoder_stream

Overview:
- Streaming systematic-free (non-systematic) polar encoder: the transmit-side counterpart to the SC / look-ahead decoder nodes.
- Accepts K info bits serially over valid/ready and inserts frozen zeros per a compile-time mask to form u[0..N-1].
- Computes x = u·F^{⊗n}, F=[[1,0],[1,1]], one butterfly stage per cycle, then streams x[0..N-1] serially with backpressure.
- Feeds the channel model / decoder bench as the codeword source.

Parameters:
- N, 8, code length; power of two, 2..1024.
- K, 4, info bits per frame; 1..N.
- FROZEN_MASK, 8'b0001_0111, N-bit; bit i=1 means u[i] is frozen (forced 0); popcount must equal N-K.
- LOG2N, $clog2(N), localparam, number of butterfly stages.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  info bit valid.
- in_bit  in  1  info bit, consumed in increasing non-frozen index order.
- in_ready  out  1  encoder accepts in_bit this cycle.
- out_valid  out  1  code bit valid.
- out_bit  out  1  code bit x[idx].
- out_last  out  1  high with x[N-1].
- out_ready  in  1  sink accepts out_bit.
- busy  out  1  high in any state other than COLLECT with zero bits captured.

Behaviour:
- Reset (async assert, sync release): state=COLLECT, u register=0, bit/stage/out counters=0. Outputs: in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0.
- COLLECT: in_ready=1. On in_valid&in_ready:
  - write in_bit to u[p], where p is the next non-frozen index (pointer advances past frozen positions).
  - info counter increments.
  - on the K-th accept, go to ENCODE; stage=0.
  - frozen positions always hold 0.
- ENCODE: in_ready=0. Each cycle applies stage s (d=2^s): for every i with bit s of i clear, v[i] ^= v[i+d]; v[i+d] is unchanged. Runs exactly LOG2N cycles, then goes to EMIT with idx=0.
- EMIT: out_valid=1, out_bit=v[idx], out_last=(idx==N-1).
  - On out_ready: idx++.
  - On the transfer with out_last: go to COLLECT and clear v.
  - out_bit and out_last stay stable while out_valid & !out_ready.
- Latency: first out_valid occurs LOG2N+1 cycles after the clock edge accepting the K-th info bit (1 cycle registered transition + LOG2N stages).
- No overlap: in_ready=0 from the K-th accept until the cycle after the last output transfer. The next frame may start in that cycle.
- in_valid while in_ready=0 is ignored. The source holds the bit.
- K==N (mask 0): no frozen skipping. K==1: a single accept then ENCODE.
- rst_n asserted mid-frame: partial frame discarded, all state returns to reset values immediately.
- Elaboration: error if N is not a power of two or popcount(FROZEN_MASK)!=N-K.

Optional Feature:
- POLAR_ENC_BIT_REVERSE_EN defined: EMIT outputs v[bitrev_LOG2N(idx)], producing x in bit-reversed order (x = u·B_N·F^{⊗n}) to match bit-reversed decoder ordering. out_last is still on the N-th transfer.
- Undefined: natural order v[idx].
- Frozen mapping, latency and handshake are identical in both builds.

Decomposition:
- Package polar_pkg holds:
  - F kernel convention constant.
  - default N=8/K=4 FROZEN_MASK constant.
  - functions clog2_pow2 and bitrev(idx,width).
  - enum enc_state_t {COLLECT, ENCODE, EMIT}.
- Natural sub-module: polar_butterfly_stage. It is combinational over N bits, with stage index input s; it returns v with v[i]^=v[i+2^s] for pairs. The top instantiates it once and iterates it over cycles.

Test Plan:
- N=8, K=4, mask 0x17, info 1,1,1,1 → u=[0,0,0,1,0,1,1,1], serial x0..x7 = 0,1,1,0,1,0,0,1; out_last only on x7; first out_valid 4 cycles after the 4th accept.
- Info 0,0,0,1 (only u7) → x = 1,1,1,1,1,1,1,1. Info 1,0,0,0 (only u3) → x = 1,1,1,1,0,0,0,0.
- Backpressure: out_ready toggled 1,0,0,1,… during EMIT → out_bit/out_last held stable while stalled, no bit lost or duplicated, in_ready=0 throughout.
- Back-to-back frames with in_valid held high → second frame's first accept occurs the cycle after the first frame's out_last transfer; both codewords are correct.
- rst_n pulsed low after 2 info bits → out_valid=0, in_ready=1 at once; the next 4 bits 1,1,1,1 yield 0,1,1,0,1,0,0,1.
- With POLAR_ENC_BIT_REVERSE_EN, info 1,1,1,1 → output order x0,x4,x2,x6,x1,x5,x3,x7 = 0,1,1,0,1,0,0,1.
